// File: rtl/mlp_pkg.sv
// Shared constants, state encoding and address helper for the MLP load sequencer.
package mlp_pkg;

  localparam int N_LAYERS    = 8;
  localparam int ROWS        = 16;
  localparam int WPR         = 8;
  localparam int LAYER_GAP   = 4;
  localparam int RES_WORDS   = 128;
  localparam int TIMEOUT     = 4096;
  localparam int AW          = 12;
  localparam int DW          = 32;
  localparam int BURST_WORDS = ROWS * WPR;
  localparam int WEIGHT_BASE = 128;

  // Terminal values, sized to the counters that compare against them.
  localparam logic [3:0]  ROW_LAST   = 4'(ROWS - 1);
  localparam logic [2:0]  WORD_LAST  = 3'(WPR - 1);
  localparam logic [2:0]  LAYER_LAST = 3'(N_LAYERS - 1);
  localparam logic [2:0]  GAP_LAST   = 3'(LAYER_GAP - 1);
  localparam logic [11:0] TMO_LAST   = 12'(TIMEOUT - 1);
  localparam logic [6:0]  RES_LAST   = 7'(RES_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_IN,
    LOAD_W,
    GAP,
    WAIT_RES,
    DONE,
    ERR
  } state_t;

  // Weights of layer L follow the input matrix, one 128-word block per layer.
  function automatic logic [AW-1:0] weight_addr(input logic [2:0] layer, input logic [6:0] idx);
    return AW'(WEIGHT_BASE) + AW'(layer) * AW'(BURST_WORDS) + AW'(idx);
  endfunction

endpackage

// File: rtl/mlp_load_sequencer_if.sv
// Tagged load stream from the sequencer to the accelerator.
interface mlp_load_sequencer_if;
  import mlp_pkg::*;

  logic          load_en;
  logic [DW-1:0] load_payload;
  logic          load_type;
  logic [3:0]    input_load_number;
  logic [3:0]    layer_number;
  logic [2:0]    weight_number;

  modport master (
    output load_en, load_payload, load_type,
    output input_load_number, layer_number, weight_number
  );

  modport slave (
    input load_en, load_payload, load_type,
    input input_load_number, layer_number, weight_number
  );

endinterface

// File: rtl/mlp_load_addr_gen.sv
// Row/word/layer counters, buffer address and the tag pipeline stage that
// lines the tags up with read data returning one cycle after the read.
module mlp_load_addr_gen
  import mlp_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          issue,
  input  logic          input_phase,
  input  logic          next_layer,
  output logic [AW-1:0] addr,
  output logic          last_word,
  output logic          last_layer,
  output logic          tag_valid,
  output logic          tag_type,
  output logic [3:0]    tag_row,
  output logic [3:0]    tag_layer,
  output logic [2:0]    tag_word
);

  logic [3:0] row;
  logic [2:0] word;
  logic [2:0] layer;
  logic [6:0] idx;

  assign idx        = {row, word};
  assign last_word  = (row == ROW_LAST) && (word == WORD_LAST);
  assign last_layer = (layer == LAYER_LAST);
  assign addr       = input_phase ? AW'(idx) : weight_addr(layer, idx);

  // Walk words inside a row, then rows; layer only advances when the FSM asks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row   <= '0;
      word  <= '0;
      layer <= '0;
    end else if (clear) begin
      row   <= '0;
      word  <= '0;
      layer <= '0;
    end else begin
      if (issue) begin
        if (word == WORD_LAST) begin
          word <= '0;
          row  <= (row == ROW_LAST) ? '0 : row + 4'd1;
        end else begin
          word <= word + 3'd1;
        end
      end
      if (next_layer) begin
        layer <= layer + 3'd1;
      end
    end
  end

  // Register the tags of each issued read so they meet the returning data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= 1'b0;
      tag_type  <= 1'b0;
      tag_row   <= '0;
      tag_layer <= '0;
      tag_word  <= '0;
    end else begin
      tag_valid <= issue;
      tag_type  <= issue && input_phase;
      tag_row   <= issue ? row : '0;
      tag_layer <= (issue && !input_phase) ? {1'b0, layer} : '0;
      tag_word  <= issue ? word : '0;
    end
  end

endmodule

// File: rtl/mlp_load_sequencer.sv
// Host-side load sequencer: streams inputs and all layer weights out of the
// buffer with tags, then captures the result stream into the result buffer.
module mlp_load_sequencer
  import mlp_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o,
  output logic          mem_rd_en_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic [DW-1:0] mem_rdata_i,
  mlp_load_sequencer_if.master load,
  input  logic          result_valid_i,
  input  logic [DW-1:0] result_payload_i,
  output logic          res_we_o,
  output logic [6:0]    res_addr_o,
  output logic [DW-1:0] res_wdata_o
);

  state_t        state, state_next;
  logic          rd_en, clear, input_phase, next_layer, start_acc, res_acc;
  logic [AW-1:0] addr;
  logic          last_word, last_layer;
  logic          tag_valid, tag_type;
  logic [3:0]    tag_row, tag_layer;
  logic [2:0]    tag_word;
  logic [2:0]    gap_cnt;
  logic [11:0]   tmo_cnt;
  logic [6:0]    res_cnt;

  mlp_load_addr_gen u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .issue       (rd_en),
    .input_phase (input_phase),
    .next_layer  (next_layer),
    .addr        (addr),
    .last_word   (last_word),
    .last_layer  (last_layer),
    .tag_valid   (tag_valid),
    .tag_type    (tag_type),
    .tag_row     (tag_row),
    .tag_layer   (tag_layer),
    .tag_word    (tag_word)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Sequencing: input burst, weight bursts separated by gaps, then result wait.
  always_comb begin
    state_next  = state;
    rd_en       = 1'b0;
    clear       = 1'b0;
    input_phase = 1'b0;
    next_layer  = 1'b0;
    start_acc   = 1'b0;
    res_acc     = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_next = LOAD_IN;
          clear      = 1'b1;
          start_acc  = 1'b1;
        end
      end
      LOAD_IN: begin
        rd_en       = 1'b1;
        input_phase = 1'b1;
        if (last_word) state_next = LOAD_W;
      end
      LOAD_W: begin
        rd_en = 1'b1;
        if (last_word) begin
          if (last_layer) begin
            state_next = WAIT_RES;
          end else begin
            state_next = GAP;
            next_layer = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_next = LOAD_W;
      end
      WAIT_RES: begin
        if (result_valid_i) begin
          res_acc = 1'b1;
          if (res_cnt == RES_LAST) state_next = DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_next = ERR;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Gap length, result-silence timeout and captured result count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
      tmo_cnt <= '0;
      res_cnt <= '0;
    end else begin
      gap_cnt <= (state == GAP && gap_cnt != GAP_LAST) ? gap_cnt + 3'd1 : '0;
      tmo_cnt <= (state == WAIT_RES && !result_valid_i) ? tmo_cnt + 12'd1 : '0;
      if (start_acc) begin
        res_cnt <= '0;
      end else if (res_acc) begin
        res_cnt <= (res_cnt == RES_LAST) ? '0 : res_cnt + 7'd1;
      end
    end
  end

  // Registered result-buffer write and the sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_we_o    <= 1'b0;
      res_addr_o  <= '0;
      res_wdata_o <= '0;
      error_o     <= 1'b0;
    end else begin
      res_we_o    <= res_acc;
      res_addr_o  <= res_acc ? res_cnt : '0;
      res_wdata_o <= res_acc ? result_payload_i : '0;
      if (start_acc)               error_o <= 1'b0;
      else if (state_next == ERR)  error_o <= 1'b1;
    end
  end

  assign busy_o      = (state == LOAD_IN) || (state == LOAD_W) || (state == GAP) || (state == WAIT_RES);
  assign done_o      = (state == DONE);
  assign mem_rd_en_o = rd_en;
  assign mem_addr_o  = rd_en ? addr : '0;

  assign load.load_en           = tag_valid;
  assign load.load_payload      = tag_valid ? mem_rdata_i : '0;
  assign load.load_type         = tag_type;
  assign load.input_load_number = tag_row;
  assign load.layer_number      = tag_layer;
  assign load.weight_number     = tag_word;

endmodule

// File: tb/tb_mlp_load_sequencer.sv
// Self-checking bench for mlp_load_sequencer against a word-list reference model.
module tb_mlp_load_sequencer;
  import mlp_pkg::*;

  localparam int TOTAL_BEATS = BURST_WORDS * (N_LAYERS + 1);

  typedef struct packed {
    logic [31:0] cyc;
    logic        typ;
    logic [3:0]  r;
    logic [3:0]  l;
    logic [2:0]  w;
    logic [31:0] p;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic          busy, done, error;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic          res_valid;
  logic [31:0]   res_payload;
  logic          res_we;
  logic [6:0]    res_addr;
  logic [31:0]   res_wdata;

  int unsigned   cyc = 0;
  int            n_assert = 0;
  int            n_fail = 0;
  int            done_count = 0;
  beat_t         beats[$];
  logic [38:0]   writes[$];
  logic [38:0]   exp_res[$];

  mlp_load_sequencer_if lif ();

  mlp_load_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start_i),
    .busy_o           (busy),
    .done_o           (done),
    .error_o          (error),
    .mem_rd_en_o      (mem_rd_en),
    .mem_addr_o       (mem_addr),
    .mem_rdata_i      (mem_rdata),
    .load             (lif),
    .result_valid_i   (res_valid),
    .result_payload_i (res_payload),
    .res_we_o         (res_we),
    .res_addr_o       (res_addr),
    .res_wdata_o      (res_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sync-read buffer preloaded with data = address; garbage when not read.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= {20'd0, mem_addr};
    else           mem_rdata <= $urandom;
  end

  // Record every load beat, result write and done pulse.
  always @(negedge clk) begin
    beat_t b;
    if (lif.load_en) begin
      b.cyc = cyc;
      b.typ = lif.load_type;
      b.r   = lif.input_load_number;
      b.l   = lif.layer_number;
      b.w   = lif.weight_number;
      b.p   = lif.load_payload;
      beats.push_back(b);
    end
    if (res_we) writes.push_back({res_addr, res_wdata});
    if (done) done_count++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] payload);
    res_valid   = valid;
    res_payload = payload;
    step();
  endtask

  task automatic startRun(output int unsigned c0);
    beats.delete();
    writes.delete();
    start_i = 1'b1;
    c0 = cyc;
    step();
    start_i = 1'b0;
  endtask

  // Wait for n beats; optionally fire garbage results and a stray start meanwhile.
  task automatic waitBeats(input int n, input int budget, input bit noisy);
    int i;
    i = 0;
    while (beats.size() < n && i < budget) begin
      if (noisy && beats.size() < 1000) begin
        res_valid   = 1'($urandom_range(0, 1));
        res_payload = $urandom;
        start_i     = (i == 200);
      end else begin
        res_valid = 1'b0;
        start_i   = 1'b0;
      end
      step();
      i++;
    end
    res_valid = 1'b0;
    start_i   = 1'b0;
    checkOutput($sformatf("beats_reached_%0d", n), 64'(beats.size() >= n), 64'd1);
  endtask

  // Expected stream: 128 input words, then each layer's 128 weights, gaps of LAYER_GAP.
  task automatic verifyBeats(input int unsigned c0);
    beat_t b;
    int    l, i;
    logic [43:0] exp_f;
    int unsigned exp_c;
    checkOutput("load_en_total", 64'(beats.size()), 64'(TOTAL_BEATS));
    for (int k = 0; k < TOTAL_BEATS; k++) begin
      b = (k < beats.size()) ? beats[k] : '0;
      if (k < BURST_WORDS) begin
        exp_f = {1'b1, 4'(k / WPR), 4'd0, 3'(k % WPR), 32'(k)};
        exp_c = c0 + 2 + k;
      end else begin
        l = (k - BURST_WORDS) / BURST_WORDS;
        i = (k - BURST_WORDS) % BURST_WORDS;
        exp_f = {1'b0, 4'(i / WPR), 4'(l), 3'(i % WPR), 32'(WEIGHT_BASE + l * BURST_WORDS + i)};
        exp_c = c0 + 2 + k + LAYER_GAP * l;
      end
      checkOutput($sformatf("beat%0d_fields", k), 64'({b.typ, b.r, b.l, b.w, b.p}), 64'(exp_f));
      checkOutput($sformatf("beat%0d_cycle", k), 64'(b.cyc), 64'(exp_c));
    end
  endtask

  initial begin
    int unsigned c0;
    int          n, dc;
    beat_t       b;
    logic [31:0] pl;

    rst_n       = 1'b0;
    start_i     = 1'b0;
    res_valid   = 1'b0;
    res_payload = '0;

    // Reset state.
    repeat (3) step();
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_error", 64'(error), 64'd0);
    checkOutput("rst_rd_en", 64'(mem_rd_en), 64'd0);
    checkOutput("rst_load_en", 64'(lif.load_en), 64'd0);
    checkOutput("rst_res_we", 64'(res_we), 64'd0);
    rst_n = 1'b1;
    repeat ($urandom_range(1, 5)) step();

    // Run 1: full load stream, then 128 randomly spaced results.
    $display("[TB] run 1: full inference");
    startRun(c0);
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    waitBeats(TOTAL_BEATS, 1400, 1'b1);
    repeat (20) step();
    verifyBeats(c0);
    b = (beats.size() > 554) ? beats[554] : '0;
    checkOutput("w_L3_r5_w2", 64'({b.l, b.r, b.w, b.p}), 64'({4'd3, 4'd5, 3'd2, 32'd554}));
    checkOutput("no_res_during_load", 64'(writes.size()), 64'd0);

    exp_res.delete();
    for (int i = 0; i < RES_WORDS; i++) begin
      repeat ($urandom_range(0, 2)) applyStimulus(1'b0, '0);
      pl = $urandom;
      exp_res.push_back({7'(i), pl});
      checkOutput("done_not_early", 64'(done_count), 64'd0);
      applyStimulus(1'b1, pl);
    end
    res_valid = 1'b0;
    checkOutput("done_pulse", 64'(done), 64'd1);
    checkOutput("busy_falls_with_done", 64'(busy), 64'd0);
    repeat (3) applyStimulus(1'b1, $urandom);
    res_valid = 1'b0;
    checkOutput("done_single", 64'(done), 64'd0);
    repeat (3) step();
    checkOutput("done_count", 64'(done_count), 64'd1);
    checkOutput("error_clean", 64'(error), 64'd0);
    checkOutput("res_write_count", 64'(writes.size()), 64'(RES_WORDS));
    for (int i = 0; i < RES_WORDS; i++) begin
      checkOutput($sformatf("res%0d", i), 64'((i < writes.size()) ? writes[i] : '0), 64'(exp_res[i]));
    end

    // Run 2: only 100 results, then silence until timeout.
    $display("[TB] run 2: result timeout");
    startRun(c0);
    waitBeats(TOTAL_BEATS, 1400, 1'b0);
    repeat (5) step();
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, $urandom);
    res_valid = 1'b0;
    dc = done_count;
    n = 0;
    while (!error && n < 5000) begin
      step();
      n++;
    end
    checkOutput("timeout_cycles", 64'(n), 64'(TIMEOUT));
    checkOutput("busy_after_err", 64'(busy), 64'd0);
    repeat (3) step();
    checkOutput("error_sticky", 64'(error), 64'd1);
    checkOutput("no_done_on_err", 64'(done_count), 64'(dc));
    checkOutput("res_writes_partial", 64'(writes.size()), 64'd100);
    startRun(c0);
    checkOutput("error_cleared", 64'(error), 64'd0);
    checkOutput("busy_restart", 64'(busy), 64'd1);

    // Asynchronous reset in the middle of layer 2 weights.
    waitBeats(BURST_WORDS * 3 + 50, 800, 1'b0);
    checkOutput("load_en_before_reset", 64'(lif.load_en), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_load_en", 64'(lif.load_en), 64'd0);
    checkOutput("async_busy", 64'(busy), 64'd0);
    checkOutput("async_rd_en", 64'(mem_rd_en), 64'd0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checkOutput("no_done_after_reset", 64'(done_count), 64'(dc));

    // Restart after reset begins again at input word 0.
    $display("[TB] run 3: restart after reset");
    startRun(c0);
    waitBeats(TOTAL_BEATS, 1400, 1'b0);
    repeat (20) step();
    verifyBeats(c0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
